// File: rtl/mul_sequencer_if.sv
// Core-side bundle for the HI/LO multiply unit: multiply request, HI/LO moves and status.
// The core drives through master; the multiply unit sits on slave.
interface mul_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, sign, a, b, rd, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, sign, a, b, rd, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add HI/LO multiplier for the MIPS core.
// Owns HI/LO and raises stall while a product is still being formed.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic                 done_reg;
  logic [WIDTH:0]       partial_sum;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  // Signed operands are reduced to magnitudes; -2^(W-1) negates to itself, which is the right unsigned value.
  function automatic logic [WIDTH-1:0] magnitude(input logic is_signed, input logic [WIDTH-1:0] v);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  assign partial_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign product     = neg ? -acc : acc;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moves are only honoured in IDLE and lose to a coincident start; HI/LO otherwise change only in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= magnitude(bus.sign, bus.a);
            acc   <= {{WIDTH{1'b0}}, magnitude(bus.sign, bus.b)};
            cnt   <= '0;
            neg   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wdata;
            if (bus.wr_lo) lo_reg <= bus.wdata;
          end
        end
        RUN: begin
          acc <= {partial_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          {hi_reg, lo_reg} <= product;
          done_reg         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = busy;
  assign bus.done  = done_reg;
  assign bus.stall = busy & (bus.rd | bus.start | bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random multiplies against a
// plain-arithmetic 64-bit product model, plus handshake, move and reset checks.
module tb_mul_sequencer;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: full 64-bit product from ordinary signed/unsigned arithmetic
  function automatic logic [63:0] refProduct(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sp;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      sp = sx * sy;
      return sp;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic applyStimulus(input bit st, input bit sg, input logic [31:0] x, input logic [31:0] y,
                               input bit r, input bit wh, input bit wl, input logic [31:0] wd);
    bus.start = st;
    bus.sign  = sg;
    bus.a     = x;
    bus.b     = y;
    bus.rd    = r;
    bus.wr_hi = wh;
    bus.wr_lo = wl;
    bus.wdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One multiply from an idle (or done) cycle through the done cycle; optional mid-run probes
  task automatic runMul(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                        input bit probe, input bit start_write);
    logic [63:0] p;
    int busy_cycles;
    int done_seen;
    p = refProduct(sgn, x, y);
    applyStimulus(1'b1, sgn, x, y, 1'b0, 1'b0, start_write, $urandom);
    #1;
    checkOutput("stall_at_accept", bus.stall, 0);
    tick;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    busy_cycles = 0;
    done_seen   = 0;
    for (int k = 0; k <= 32; k++) begin
      busy_cycles += int'(bus.busy);
      done_seen   += int'(bus.done);
      if (k == 16) begin
        checkOutput("hold_hi", bus.hi, model_hi);
        checkOutput("hold_lo", bus.lo, model_lo);
      end
      if (probe && k == 5) begin
        applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("stall_start_busy", bus.stall, 1);
      end
      if (probe && k == 10) begin
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        checkOutput("stall_rd_busy", bus.stall, 1);
      end
      if (probe && k == 15) begin
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, $urandom);
        #1;
        checkOutput("stall_wr_busy", bus.stall, 1);
      end
      tick;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    end
    checkOutput("busy_cycles", busy_cycles, 33);
    checkOutput("early_done", done_seen, 0);
    checkOutput("done_pulse", bus.done, 1);
    checkOutput("busy_after", bus.busy, 0);
    checkOutput("result_hi", bus.hi, p[63:32]);
    checkOutput("result_lo", bus.lo, p[31:0]);
    model_hi = p[63:32];
    model_lo = p[31:0];
  endtask

  initial begin
    int done_seen;
    logic [31:0] wd;

    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    #20 reset = 1'b0;
    tick;

    // rd in IDLE never stalls
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    #1;
    checkOutput("stall_rd_idle", bus.stall, 0);
    tick;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Directed products, issued back-to-back from each done cycle
    $display("[TB] directed multiplies");
    runMul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runMul(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    runMul(1'b1, 32'd7, 32'd6, 1'b0, 1'b0);
    runMul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    runMul(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    tick;
    checkOutput("done_drop", bus.done, 0);

    // Handshake probes: ignored start, rd/wr stalls, then a back-to-back 2*3
    $display("[TB] handshake");
    runMul(1'b0, $urandom, $urandom, 1'b1, 1'b0);
    runMul(1'b0, 32'd2, 32'd3, 1'b0, 1'b0);
    tick;

    // Random operands and signedness
    $display("[TB] random multiplies");
    for (int i = 0; i < 6; i++) begin
      runMul(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'b0);
    end
    tick;

    // Moves in IDLE
    $display("[TB] moves");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 32'h0000_1234);
    tick;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_hi = 32'h0000_1234;
    checkOutput("move_hi", bus.hi, model_hi);
    checkOutput("move_hi_lo_kept", bus.lo, model_lo);
    wd = $urandom;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, wd);
    tick;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_hi = wd;
    model_lo = wd;
    checkOutput("move_both_hi", bus.hi, model_hi);
    checkOutput("move_both_lo", bus.lo, model_lo);
    runMul(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    tick;

    // Reset in the middle of RUN discards the product
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, '0);
    tick;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (10) tick;
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_hi", bus.hi, 0);
    checkOutput("midreset_lo", bus.lo, 0);
    model_hi = '0;
    model_lo = '0;
    #1 reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      done_seen += int'(bus.done);
    end
    checkOutput("midreset_no_done", done_seen, 0);
    runMul(1'b0, $urandom, $urandom, 1'b0, 1'b0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
